// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle signed divider.
// Iteration count, counter width, state encoding and magnitude helper.
package div_pkg;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned DIV_CNT_W = 6;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

  typedef enum logic {
    ITER = 1'b0,
    DONE = 1'b1
  } div_state_e;

  // Two's-complement magnitude; INT_MIN maps to itself as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
// Groups ripple their carry; each group resolves its internal carries in parallel.
module cla_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = cin_i;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign sum_o  = p ^ c[31:0];
  assign cout_o = c[32];

endmodule

// File: rtl/div_control.sv
// Sequencer for the divider: step counter plus ITER/DONE state.
// A high ctr_rst restarts the sequence; stepping begins on the first low edge.
module div_control
  import div_pkg::*;
(
  input  logic clock,
  input  logic ctr_rst,
  output logic step_en,
  output logic last_step,
  output logic done
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_ITERS - 1);

  div_state_e           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;

  // Count restoring steps; the step at LAST_CNT retires into DONE.
  always_ff @(posedge clock) begin
    if (ctr_rst) begin
      cnt_q   <= '0;
      state_q <= ITER;
    end else if (state_q == ITER) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) state_q <= DONE;
    end
  end

  assign step_en   = ~ctr_rst & (state_q == ITER);
  assign last_step = step_en & (cnt_q == LAST_CNT);
  assign done      = (state_q == DONE);

endmodule

// File: rtl/div.sv
// Multi-cycle signed 32-bit restoring divider, one quotient bit per clock.
// Quotient truncates toward zero; flags divide-by-zero and INT_MIN / -1.
module div
  import div_pkg::*;
(
  input  logic        clock,
  input  logic        ctr_rst,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic        sa_q;
  logic        sb_q;
  logic        ovf_q;
  logic [31:0] res_q;
  logic        exc_q;
  logic        rdy_q;

  logic        step_en;
  logic        last_step;
  logic        done;

  logic [31:0] trial;
  logic [31:0] diff;
  logic        sub_co;
  logic        t_neg;
  logic [31:0] quo_d;
  logic [31:0] rem_d;
  logic [31:0] quo_neg;
  logic        neg_co_unused;
  logic        dz;
  logic [31:0] res_d;

  div_control u_ctrl (
    .clock     (clock),
    .ctr_rst   (ctr_rst),
    .step_en   (step_en),
    .last_step (last_step),
    .done      (done)
  );

  // Remainder is always below the divisor, so its dropped top bit is zero.
  assign trial = {rem_q[30:0], quo_q[31]};

  cla_32 u_sub (
    .a_i    (trial),
    .b_i    (~dvs_q),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (sub_co)
  );

  assign t_neg = ~(rem_q[31] ^ sub_co);
  assign quo_d = {quo_q[30:0], ~t_neg};
  assign rem_d = t_neg ? trial : diff;

  cla_32 u_neg (
    .a_i    (~quo_d),
    .b_i    (32'h0),
    .cin_i  (1'b1),
    .sum_o  (quo_neg),
    .cout_o (neg_co_unused)
  );

  assign dz    = (dvs_q == 32'h0);
  assign res_d = dz ? 32'h0 : ((sa_q ^ sb_q) ? quo_neg : quo_d);

  // Load operands on ctr_rst, step while iterating, register result on last step.
  always_ff @(posedge clock) begin
    if (ctr_rst) begin
      quo_q <= abs32(data_operandA);
      dvs_q <= abs32(data_operandB);
      rem_q <= '0;
      sa_q  <= data_operandA[31];
      sb_q  <= data_operandB[31];
      ovf_q <= (data_operandA == INT_MIN) & (data_operandB == NEG_ONE);
      res_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
    end else if (step_en) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      if (last_step) begin
        res_q <= res_d;
        exc_q <= dz | ovf_q;
        rdy_q <= 1'b1;
      end
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q & done;

endmodule
